planificador_ascensor: RTL and testbench
========================================

Name: planificador_ascensor

Overview:
- Sequential scheduler for a 4-floor elevator.
- Latches hall and cabin requests and picks the travel direction.
- Drives the hoist motor and presents the stopped/moving state word to the combinational door controller. It waits on that controller's `trabajando` flag before moving again.

Parameters:
- CICLOS_PISO, 16, clock cycles of motor travel between adjacent floors (>=2)
- CICLOS_RETORNO, 1024, idle cycles before return-to-floor-1 (used only with the optional feature)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- botones  in  10  request buttons, level or pulse
  - bit0 floor1 call; bits1/2 floor2 down/up; bits3/4 floor3 down/up; bit5 floor4 call
  - bits6-9 cabin buttons for floors 1-4
- puertas  in  2  door status: 00 closed, 01 open, 10 closing, 11 opening
- trabajando  in  1  door controller busy
- pisos  out  10  latched pending requests, same bit map as botones
- estado  out  4  [1:0] floor 0-3; [2] direction, 1 = up; [3] moving
- motor  out  2  01 up, 10 down, 00 stop
- fallo  out  1  door-interlock fault flag

Behaviour:
- All outputs are registered. Reset values:
  - pisos=0, estado=4'b0100 (floor 0, up, stopped), motor=00, fallo=0
  - FSM=REPOSO, travel counter=0
- Request latch, every cycle: pisos <= (pisos | botones) & ~servir.
  - servir is nonzero only in PUERTAS with puertas==01.
  - A clear wins over a press of the same bit in the same cycle.
  - In FALLA the latch freezes.
- servir(f,d) = cabin bit 6+f, plus the hall bit for that floor:
  - f0: bit0; f3: bit5
  - f1: bit2 if d=1 else bit1
  - f2: bit4 if d=1 else bit3
- Derived signals:
  - aqui = any servir(f,d) bit pending
  - arriba = any request at a floor above f; abajo = any request below f
  - contraria = only the opposite-direction hall bit pending at f
- FSM REPOSO, with estado[3]=0 and motor=00. Priority order:
  1. aqui -> PUERTAS
  2. d=1 & arriba -> MOVIENDO up
  3. abajo -> d<=0, MOVIENDO down
  4. arriba -> d<=1, MOVIENDO up
  5. contraria -> d<=~d, stay in REPOSO (re-evaluated next cycle)
  6. else idle
  - MOVIENDO entry additionally requires puertas==00; otherwise remain in REPOSO.
  - On MOVIENDO entry: counter<=CICLOS_PISO-1, estado[3]<=1, motor per direction.
- FSM PUERTAS:
  - Minimum residence 2 cycles.
  - Exit to REPOSO when trabajando==0 and puertas==00.
  - No timeout; the door controller owns door timing.
- FSM MOVIENDO:
  - Counter decrements each cycle.
  - At 0: floor <= floor±1.
  - At arrival floor 0 force d=1; at floor 3 force d=0.
  - Stop (estado[3]<=0, motor<=00, -> REPOSO) if the new floor has servir(f,d) pending or nothing lies further ahead. Otherwise reload the counter and continue.
  - Floor never leaves 0..3.
  - Latency from press to motor start while idle with doors closed: 2 cycles (latch, then decision).
- FSM FALLA:
  - Entered from MOVIENDO when puertas!=00 in any cycle.
  - motor<=00 in the same registered update, estado[3]<=0, fallo<=1.
  - Exit only via reset.
- Reset mid-travel returns to floor 0 state immediately; the physical re-homing is outside this block's scope.
- Requests for the current floor arriving during MOVIENDO are held until after the next stop.

Optional Feature:
- Macro ASCENSOR_RETORNO_EN.
- Defined:
  - Idle counter increments in REPOSO when pisos==0 and floor!=0; it clears otherwise.
  - On reaching CICLOS_RETORNO it sets pisos[6] internally, and the elevator returns to floor 1 through normal scheduling.
- Undefined:
  - No idle counter; the elevator parks at its last floor indefinitely.
  - CICLOS_RETORNO is unused.

Test Plan:
- Reset, then botones=10'b1000000000 pulsed 1 cycle, puertas=00, trabajando=0, CICLOS_PISO=4:
  - pisos[9]=1 next cycle; motor=01 one cycle later.
  - estado[1:0] steps 0->1->2->3, one floor every 4 cycles.
  - At floor 3: estado=4'b0011, motor=00.
- At floor 3 stopped, pisos bit9 pending, puertas driven 00->11->01:
  - FSM=PUERTAS; bit9 clears in the first cycle with puertas==01.
  - With trabajando=0 and puertas=00: back to REPOSO, estado[3]=0.
- At floor 0 moving up, floor2-down (bit3) and cabin floor 4 (bit9) pending:
  - Passes floor 2 without stopping; stops at floor 3.
  - Then reverses (d=0), stops at floor 2, and serves bit3.
- Idle at floor 1 (estado[1:0]=1), d=1, only bit1 pending:
  - Direction flips to 0 in one cycle, then PUERTAS; bit1 cleared.
- During MOVIENDO force puertas=11:
  - Next cycle motor=00, fallo=1, FSM=FALLA.
  - Further button presses are ignored; only reset restores estado=4'b0100 and fallo=0.
- With ASCENSOR_RETORNO_EN, CICLOS_RETORNO=8, idle at floor 2 with pisos=0:
  - After 8 cycles pisos[6]=1 and motor=10; the elevator arrives at floor 0.
  - Without the macro, motor stays 00 for 100 cycles.

Source files
------------

// File: rtl/planificador_ascensor_if.sv
// Request/door/motor bundle of the 4-floor elevator scheduler.
// slave: scheduler side (buttons, door status in; requests, state, motor out).
// master: environment side (drives buttons/doors, observes the scheduler).

interface planificador_ascensor_if;

    logic [9:0] botones;
    logic [1:0] puertas;
    logic       trabajando;
    logic [9:0] pisos;
    logic [3:0] estado;
    logic [1:0] motor;
    logic       fallo;

    modport master (
        output botones,
        output puertas,
        output trabajando,
        input  pisos,
        input  estado,
        input  motor,
        input  fallo
    );

    modport slave (
        input  botones,
        input  puertas,
        input  trabajando,
        output pisos,
        output estado,
        output motor,
        output fallo
    );

endinterface

// File: rtl/planificador_ascensor.sv
// Sequential scheduler for a 4-floor elevator: latches hall/cabin requests,
// picks the travel direction, drives the hoist motor and trips on door faults.
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high
//   bus   - slave modport of planificador_ascensor_if
//             botones[9:0]  request buttons (bit0 f1, 1/2 f2 dn/up,
//                           3/4 f3 dn/up, 5 f4, 6..9 cabin f1..f4)
//             puertas[1:0]  00 closed, 01 open, 10 closing, 11 opening
//             trabajando    door controller busy
//             pisos[9:0]    latched pending requests
//             estado[3:0]   {moving, dir up, floor[1:0]}
//             motor[1:0]    01 up, 10 down, 00 stop
//             fallo         door-interlock fault (sticky until reset)
//
// Optional feature: define ASCENSOR_RETORNO_EN to return to floor 1 after
// CICLOS_RETORNO idle cycles with no pending request.

module planificador_ascensor #(
    parameter int CICLOS_PISO    = 16,
    parameter int CICLOS_RETORNO = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    planificador_ascensor_if.slave bus
);

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] PUERTAS  = 2'd1;
    localparam logic [1:0] MOVIENDO = 2'd2;
    localparam logic [1:0] FALLA    = 2'd3;

    localparam int CW = $clog2(CICLOS_PISO);

    if (CICLOS_PISO < 2 || CICLOS_RETORNO < 1) begin : g_param_invalido
        $error("planificador_ascensor: invalid CICLOS_PISO/CICLOS_RETORNO");
    end

    // Request bits that a stop at floor f travelling in direction d serves.
    function automatic logic [9:0] mask_servir(
        input logic [1:0] f,
        input logic       d
    );
        logic [9:0] m;
        m = '0;
        unique case (f)
            2'd0:    m = 10'b0001000001;
            2'd1:    m = d ? 10'b0010000100 : 10'b0010000010;
            2'd2:    m = d ? 10'b0100010000 : 10'b0100001000;
            default: m = 10'b1000100000;
        endcase
        return m;
    endfunction

    // Every request bit that belongs to floor f.
    function automatic logic [9:0] mask_piso(input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        unique case (f)
            2'd0:    m = 10'b0001000001;
            2'd1:    m = 10'b0010000110;
            2'd2:    m = 10'b0100011000;
            default: m = 10'b1000100000;
        endcase
        return m;
    endfunction

    // Request bits of all floors strictly above f.
    function automatic logic [9:0] mask_arriba(input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        unique case (f)
            2'd0:    m = 10'b1110111110;
            2'd1:    m = 10'b1100111000;
            2'd2:    m = 10'b1000100000;
            default: m = 10'b0000000000;
        endcase
        return m;
    endfunction

    // Request bits of all floors strictly below f.
    function automatic logic [9:0] mask_abajo(input logic [1:0] f);
        logic [9:0] m;
        m = '0;
        unique case (f)
            2'd0:    m = 10'b0000000000;
            2'd1:    m = 10'b0001000001;
            2'd2:    m = 10'b0011000111;
            default: m = 10'b0111011111;
        endcase
        return m;
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [1:0]    piso_q, piso_d;
    logic          dir_q, dir_d;
    logic          mov_q, mov_d;
    logic [1:0]    motor_q, motor_d;
    logic          fallo_q, fallo_d;
    logic [9:0]    pisos_q, pisos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_q, res_d;

    logic [9:0] servir;
    logic [9:0] retorno;
    logic       aqui;
    logic       arriba;
    logic       abajo;
    logic       contraria;
    logic [1:0] piso_nx;
    logic       dir_nx;
    logic       para;
    logic       arrancar;
    logic       sube;

`ifdef ASCENSOR_RETORNO_EN
    localparam int RW = $clog2(CICLOS_RETORNO + 1);

    logic [RW-1:0] ocio_q, ocio_d;

    // Counts idle cycles parked away from floor 1 with nothing to do;
    // on expiry it injects a cabin call for floor 1.
    always_comb begin
        ocio_d  = '0;
        retorno = '0;
        if (fsm_q == REPOSO && pisos_q == '0 && piso_q != 2'd0) begin
            if (ocio_q == RW'(CICLOS_RETORNO - 1)) begin
                retorno[6] = 1'b1;
            end else begin
                ocio_d = ocio_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ocio_q <= '0;
        end else begin
            ocio_q <= ocio_d;
        end
    end
`else
    assign retorno = '0;
`endif

    // Request latch; a clear beats a simultaneous press of the same bit.
    always_comb begin
        servir = '0;
        if (fsm_q == PUERTAS && bus.puertas == 2'b01) begin
            servir = mask_servir(piso_q, dir_q);
        end
        if (fsm_q == FALLA) begin
            pisos_d = pisos_q;
        end else begin
            pisos_d = (pisos_q | bus.botones | retorno) & ~servir;
        end
    end

    assign aqui      = |(pisos_q & mask_servir(piso_q, dir_q));
    assign arriba    = |(pisos_q & mask_arriba(piso_q));
    assign abajo     = |(pisos_q & mask_abajo(piso_q));
    assign contraria = |(pisos_q & mask_piso(piso_q)
                         & ~mask_servir(piso_q, dir_q));

    // Floor reached at the end of the current hop, saturated to 0..3.
    always_comb begin
        if (dir_q) begin
            piso_nx = (piso_q == 2'd3) ? 2'd3 : piso_q + 2'd1;
        end else begin
            piso_nx = (piso_q == 2'd0) ? 2'd0 : piso_q - 2'd1;
        end
        if (piso_nx == 2'd0) begin
            dir_nx = 1'b1;
        end else if (piso_nx == 2'd3) begin
            dir_nx = 1'b0;
        end else begin
            dir_nx = dir_q;
        end
    end

    // Stop on arrival if this floor is served or nothing lies further on.
    assign para = (|(pisos_q & mask_servir(piso_nx, dir_nx)))
                | ~(dir_nx ? |(pisos_q & mask_arriba(piso_nx))
                           : |(pisos_q & mask_abajo(piso_nx)));

    always_comb begin
        fsm_d    = fsm_q;
        piso_d   = piso_q;
        dir_d    = dir_q;
        mov_d    = mov_q;
        motor_d  = motor_q;
        fallo_d  = fallo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        arrancar = 1'b0;
        sube     = dir_q;

        unique case (fsm_q)
            REPOSO: begin
                if (aqui) begin
                    fsm_d = PUERTAS;
                    res_d = 1'b0;
                end else begin
                    if (dir_q && arriba) begin
                        arrancar = 1'b1;
                        sube     = 1'b1;
                    end else if (abajo) begin
                        arrancar = 1'b1;
                        sube     = 1'b0;
                    end else if (arriba) begin
                        arrancar = 1'b1;
                        sube     = 1'b1;
                    end else if (contraria) begin
                        // Only the opposite hall call waits here: turn
                        // around and serve it on the next decision.
                        sube = ~dir_q;
                    end
                    dir_d = sube;
                    if (arrancar && bus.puertas == 2'b00) begin
                        fsm_d   = MOVIENDO;
                        cnt_d   = CW'(CICLOS_PISO - 1);
                        mov_d   = 1'b1;
                        motor_d = sube ? 2'b01 : 2'b10;
                    end
                end
            end

            PUERTAS: begin
                // Hold at least two cycles; the door controller owns timing.
                if (!res_q) begin
                    res_d = 1'b1;
                end else if (!bus.trabajando && bus.puertas == 2'b00) begin
                    fsm_d = REPOSO;
                end
            end

            MOVIENDO: begin
                if (bus.puertas != 2'b00) begin
                    fsm_d   = FALLA;
                    mov_d   = 1'b0;
                    motor_d = 2'b00;
                    fallo_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    piso_d = piso_nx;
                    dir_d  = dir_nx;
                    if (para) begin
                        fsm_d   = REPOSO;
                        mov_d   = 1'b0;
                        motor_d = 2'b00;
                    end else begin
                        cnt_d   = CW'(CICLOS_PISO - 1);
                        motor_d = dir_nx ? 2'b01 : 2'b10;
                    end
                end
            end

            default: begin
                // FALLA is sticky; only reset leaves it.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= REPOSO;
            piso_q  <= 2'd0;
            dir_q   <= 1'b1;
            mov_q   <= 1'b0;
            motor_q <= 2'b00;
            fallo_q <= 1'b0;
            pisos_q <= '0;
            cnt_q   <= '0;
            res_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            piso_q  <= piso_d;
            dir_q   <= dir_d;
            mov_q   <= mov_d;
            motor_q <= motor_d;
            fallo_q <= fallo_d;
            pisos_q <= pisos_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.pisos  = pisos_q;
    assign bus.estado = {mov_q, dir_q, piso_q};
    assign bus.motor  = motor_q;
    assign bus.fallo  = fallo_q;

endmodule

// File: tb/tb_planificador_ascensor.sv
// Testbench for planificador_ascensor: floor/request model checked every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_planificador_ascensor;

    localparam int CP = 4;
    localparam int CR = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    planificador_ascensor_if bus ();

    planificador_ascensor #(
        .CICLOS_PISO   (CP),
        .CICLOS_RETORNO(CR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_DOORS, M_TRAVEL, M_FAULT} mphase_t;

    bit      cab[4];
    bit      hup[4];
    bit      hdn[4];
    int      flr    = 0;
    bit      up     = 1'b1;
    mphase_t ph     = M_IDLE;
    int      eta    = 0;
    int      dwell  = 0;
    int      idle_n = 0;
    bit      fault  = 1'b0;
    bit      moving = 1'b0;
    bit [1:0] mot   = 2'b00;

    function automatic bit wants(int f, bit d);
        if (cab[f]) return 1'b1;
        if (f == 0) return hup[0];
        if (f == 3) return hdn[3];
        return d ? hup[f] : hdn[f];
    endfunction

    function automatic void serve(int f, bit d);
        cab[f] = 1'b0;
        if (f == 0) hup[0] = 1'b0;
        else if (f == 3) hdn[3] = 1'b0;
        else if (d) hup[f] = 1'b0;
        else hdn[f] = 1'b0;
    endfunction

    function automatic bit any_at(int f);
        return cab[f] | hup[f] | hdn[f];
    endfunction

    function automatic bit above(int f);
        for (int g = f + 1; g < 4; g++) if (any_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit below(int f);
        for (int g = 0; g < f; g++) if (any_at(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] pack();
        return {cab[3], cab[2], cab[1], cab[0], hdn[3],
                hup[2], hdn[2], hup[1], hdn[1], hup[0]};
    endfunction

    function automatic void absorb(logic [9:0] b);
        hup[0] |= b[0];
        hdn[1] |= b[1];
        hup[1] |= b[2];
        hdn[2] |= b[3];
        hup[2] |= b[4];
        hdn[3] |= b[5];
        for (int i = 0; i < 4; i++) cab[i] |= b[6+i];
    endfunction

    always @(posedge clk) begin : model
        logic [9:0] b;
        logic [1:0] pu;
        logic       tr;
        bit         clr;
        bit         frz;
        bit         ret;
        bit         go;
        int         cf;
        bit         cd;
        b  = bus.botones;
        pu = bus.puertas;
        tr = bus.trabajando;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cab[i] = 0; hup[i] = 0; hdn[i] = 0;
            end
            flr = 0; up = 1; ph = M_IDLE; eta = 0; dwell = 0;
            idle_n = 0; fault = 0; moving = 0; mot = 2'b00;
        end else begin
            clr = (ph == M_DOORS && pu == 2'b01);
            cf  = flr;
            cd  = up;
            frz = (ph == M_FAULT);
            ret = 0;
`ifdef ASCENSOR_RETORNO_EN
            if (ph == M_IDLE && pack() == 0 && flr != 0) begin
                idle_n++;
                if (idle_n == CR) begin
                    ret = 1;
                    idle_n = 0;
                end
            end else begin
                idle_n = 0;
            end
`endif
            case (ph)
                M_IDLE: begin
                    if (wants(flr, up)) begin
                        ph = M_DOORS;
                        dwell = 0;
                    end else begin
                        go = 0;
                        if (up && above(flr)) go = 1;
                        else if (below(flr)) begin up = 0; go = 1; end
                        else if (above(flr)) begin up = 1; go = 1; end
                        else if (any_at(flr)) up = !up;
                        if (go && pu == 2'b00) begin
                            ph = M_TRAVEL;
                            moving = 1;
                            eta = CP - 1;
                            mot = up ? 2'b01 : 2'b10;
                        end
                    end
                end
                M_DOORS: begin
                    dwell++;
                    if (dwell >= 2 && !tr && pu == 2'b00) ph = M_IDLE;
                end
                M_TRAVEL: begin
                    if (pu != 2'b00) begin
                        ph = M_FAULT; mot = 2'b00; moving = 0; fault = 1;
                    end else if (eta > 0) begin
                        eta--;
                    end else begin
                        flr += up ? 1 : -1;
                        if (flr == 0) up = 1;
                        if (flr == 3) up = 0;
                        if (wants(flr, up) || !(up ? above(flr) : below(flr))) begin
                            ph = M_IDLE; moving = 0; mot = 2'b00;
                        end else begin
                            eta = CP - 1;
                            mot = up ? 2'b01 : 2'b10;
                        end
                    end
                end
                default: ;
            endcase
            if (!frz) begin
                absorb(b);
                if (ret) cab[0] = 1;
                if (clr) serve(cf, cd);
            end
        end
    end

    bit live = 1'b0;

    always @(negedge clk) begin
        if (live) begin
            chk("model_pisos", int'(bus.pisos), int'(pack()));
            chk("model_estado", int'(bus.estado),
                int'({moving, up, 2'(flr)}));
            chk("model_motor", int'(bus.motor), int'(mot));
            chk("model_fallo", int'(bus.fallo), int'(fault));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [9:0] b);
        bus.botones = b;
        @(negedge clk);
        bus.botones = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.botones = '0;
        bus.puertas = 2'b00;
        bus.trabajando = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic door_cycle();
        bus.trabajando = 1'b1;
        bus.puertas = 2'b11;
        cyc(2);
        bus.puertas = 2'b01;
        cyc(2);
        bus.puertas = 2'b10;
        cyc(1);
        bus.puertas = 2'b00;
        bus.trabajando = 1'b0;
        cyc(1);
    endtask

    task automatic wait_estado(input string nm, input logic [3:0] v,
                               input int budget, output int took);
        took = 0;
        while (bus.estado !== v && took < budget) begin
            @(negedge clk);
            took++;
        end
        chk(nm, int'(bus.estado), int'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int took;
        int bad;
        bus.botones = '0;
        bus.puertas = 2'b00;
        bus.trabajando = 1'b0;
        do_reset();
        live = 1'b1;

        chk("rst_estado", int'(bus.estado), 4'b0100);
        chk("rst_motor", int'(bus.motor), 0);
        chk("rst_fallo", int'(bus.fallo), 0);
        chk("rst_pisos", int'(bus.pisos), 0);

        // Cabin call to floor 4 from floor 1.
        press(10'b1000000000);
        chk("b_latch", int'(bus.pisos), 10'b1000000000);
        chk("b_motor_wait", int'(bus.motor), 0);
        cyc(1);
        chk("b_motor_up", int'(bus.motor), 2'b01);
        chk("b_estado_mov", int'(bus.estado), 4'b1100);
        cyc(4);
        chk("b_floor1", int'(bus.estado), 4'b1101);
        cyc(4);
        chk("b_floor2", int'(bus.estado), 4'b1110);
        cyc(4);
        chk("b_floor3_stop", int'(bus.estado), 4'b0011);
        chk("b_motor_stop", int'(bus.motor), 0);

        // Door cycle at floor 4.
        chk("c_pending", int'(bus.pisos), 10'b1000000000);
        bus.trabajando = 1'b1;
        bus.puertas = 2'b11;
        cyc(2);
        bus.puertas = 2'b01;
        cyc(1);
        chk("c_cleared", int'(bus.pisos), 0);
        cyc(1);
        bus.puertas = 2'b10;
        cyc(1);
        bus.puertas = 2'b00;
        cyc(3);
        bus.trabajando = 1'b0;
        cyc(1);
        chk("c_stopped", int'(bus.estado), 4'b0011);

        // Pass floor 3 going up, reverse and serve its down call.
        do_reset();
        press(10'b1000001000);
        wait_estado("d_stop_f4", 4'b0011, 40, took);
        chk("d_nonstop_cycles", took, 13);
        door_cycle();
        chk("d_left_down_call", int'(bus.pisos), 10'b0000001000);
        wait_estado("d_stop_f3_down", 4'b0010, 40, took);
        chk("d_down_cycles", took, 5);
        door_cycle();
        chk("d_all_served", int'(bus.pisos), 0);

        // Opposite hall call at the parked floor.
        do_reset();
        press(10'b0010000000);
        wait_estado("e_stop_f2", 4'b0101, 40, took);
        chk("e_hop_cycles", took, 5);
        door_cycle();
        chk("e_cab_served", int'(bus.pisos), 0);
        press(10'b0000000010);
        chk("e_before_flip", int'(bus.estado), 4'b0101);
        cyc(1);
        chk("e_flipped", int'(bus.estado), 4'b0001);
        door_cycle();
        chk("e_down_served", int'(bus.pisos), 0);

        // Door opens while travelling.
        press(10'b1000000000);
        cyc(2);
        chk("f_moving", int'(bus.estado), 4'b1101);
        bus.puertas = 2'b11;
        cyc(1);
        chk("f_motor_off", int'(bus.motor), 0);
        chk("f_fallo", int'(bus.fallo), 1);
        chk("f_estado", int'(bus.estado), 4'b0101);
        press(10'b0000000001);
        cyc(2);
        chk("f_frozen", int'(bus.pisos), 10'b1000000000);
        bus.puertas = 2'b00;
        cyc(3);
        chk("f_sticky", int'(bus.fallo), 1);
        do_reset();
        chk("f_rst_estado", int'(bus.estado), 4'b0100);
        chk("f_rst_fallo", int'(bus.fallo), 0);

        // Park at floor 3 with nothing pending.
        press(10'b0100000000);
        wait_estado("g_stop_f3", 4'b0110, 40, took);
        door_cycle();
`ifdef ASCENSOR_RETORNO_EN
        took = 0;
        while (bus.pisos[6] !== 1'b1 && took < 30) begin
            @(negedge clk);
            took++;
        end
        chk("g_ret_latency", took, CR);
        chk("g_ret_call", int'(bus.pisos), 10'b0001000000);
        cyc(1);
        chk("g_ret_motor", int'(bus.motor), 2'b10);
        wait_estado("g_ret_home", 4'b0100, 40, took);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.motor != 2'b00) bad++;
        end
        chk("g_parked_motor", bad, 0);
        chk("g_parked_estado", int'(bus.estado), 4'b0110);
`endif

        live = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
